param_alu_core: RTL and testbench
=================================

Name: param_alu_core

Overview:
- Parametrised successor to the current 8-bit ALU block, for the next CPU generation.
- Contains a register file of NREGS operand registers, a result register, a high-result register and a flags register.
- Executes single-cycle arithmetic/logic ops and a multi-cycle shift-add multiply.
- Sits on the main bus behind the control-word decoder:
  - the CPU top drives strobes and selects sliced from the control word;
  - this block loads from and drives onto the bus.

Parameters:
WIDTH, 8, data/bus width in bits (>=4)
NREGS, 4, number of operand registers (>=2)

Ports:
clk  in  1  single system clock; all state changes on rising edge
rst  in  1  asynchronous, active-high reset
bus_in  in  WIDTH  value currently on main bus
bus_out  out  WIDTH  value to drive onto main bus
bus_oe  out  1  bus_out valid/drive enable
load_en  in  1  load bus_in into register load_sel
load_sel  in  clog2(NREGS)  destination register index
out_en  in  1  request to drive bus
out_sel  in  clog2(NREGS+3)  0..NREGS-1 register; NREGS result; NREGS+1 result_hi; NREGS+2 flags
calc  in  1  execute op this edge
op  in  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL, 6 SHR, 7 MUL
arg_l  in  clog2(NREGS)  left operand register index
arg_r  in  clog2(NREGS)  right operand register index
use_cin  in  1  ADD/SUB take carry-in from flag C (ADC/SBC)
busy  out  1  multiply in progress
done  out  1  one-cycle pulse when multiply completes
flags  out  4  {V,N,Z,C}

Behaviour:
- Reset (async, asserted): all regs, result, result_hi, flags = 0; busy = 0; done = 0; FSM = IDLE. A mid-multiply reset aborts it and leaves no partial result.
- Load: load_en at edge writes regs[load_sel] <= bus_in. Permitted while busy: MUL operands are captured at start.
- Bus output (combinational):
  - bus_oe = out_en;
  - bus_out = selected source, zero-extended for flags;
  - out_sel values beyond NREGS+2 drive 0.
  - Reading result/result_hi while busy returns the previous values.
- Same-edge load + calc reading the same register: calc uses the pre-load value.
- Single-cycle ops (calc while IDLE): result and flags are updated at the same edge; readable the next cycle.
  - ADD: a + b + cin. cin = flag C if use_cin, else 0. C = carry out; V = signed overflow.
  - SUB: a + ~b + cin. cin = flag C if use_cin, else 1. C = 1 means no borrow; V = signed overflow.
  - AND/OR/XOR: C = 0, V = 0.
  - SHL a by 1: C = a[MSB]; V = 0.
  - SHR (logical) a by 1: C = a[0]; V = 0.
  - All ops: Z = (result == 0); N = result[MSB]. result_hi is unchanged.
- MUL (unsigned shift-add):
  - States IDLE, MUL, FINISH.
  - IDLE + calc + op==7: capture multiplicand and multiplier; clear accumulator; counter = WIDTH; busy = 1; go to MUL.
  - MUL: one multiplier bit per cycle. Go to FINISH when counter reaches 0.
  - FINISH (1 cycle): result = low WIDTH bits; result_hi = high WIDTH bits; C = (result_hi != 0); V = 0; Z and N from low part. done = 1; busy = 0; return to IDLE.
  - Total: WIDTH+1 cycles from the calc edge until done is asserted.
- calc while busy is ignored entirely: no state, result or flag change.
- Counters and shifts are modulo WIDTH; no other wrap conditions.

Decomposition:
- Package param_alu_pkg: op encoding constants, flag bit positions, out_sel encodings (as functions of NREGS), FSM state enum.
- One natural sub-module: param_alu_mul (sequential shift-add multiplier with start/busy/done); the top holds the register file, combinational ALU, flags and bus mux.

Test Plan (WIDTH=8, NREGS=4):
- Load R0=0x7F, R1=0x01; ADD l=0 r=1 -> next cycle result=0x80, flags C=0 Z=0 N=1 V=1.
- Load R2=R3=0x05; SUB l=2 r=3 -> result=0x00, Z=1 C=1 N=0 V=0; SUB 0x00-0x01 -> 0xFF, C=0 N=1.
- Set C=1 via prior SUB; ADD use_cin with 0xFF+0x00 -> result=0x00, C=1 Z=1; SHR of 0x01 -> 0x00, C=1 Z=1.
- MUL 0x10*0x20 -> busy high 8 cycles; done pulse on the 9th edge; result=0x00, result_hi=0x02, C=1 Z=1; out_sel=5 drives 0x02, bus_oe=1.
- calc ADD issued mid-MUL -> ignored, flags unchanged; assert rst mid-MUL -> busy=0, result=0, flags=0 immediately, no done pulse.
- Same-edge load R0=0xAA with ADD l=0 r=1 (old R0=0x01, R1=0x01) -> result=0x02; next read of R0=0xAA.

Source files
------------

// File: rtl/param_alu_pkg.sv
// Shared definitions for the parametrised ALU core: opcodes, flag bit
// positions, bus output select encodings and the multiplier FSM states.
package param_alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_SHL = 3'd5,
    OP_SHR = 3'd6,
    OP_MUL = 3'd7
  } alu_op_t;

  // Flags word layout is {V,N,Z,C}
  localparam int unsigned FLAG_C = 0;
  localparam int unsigned FLAG_Z = 1;
  localparam int unsigned FLAG_N = 2;
  localparam int unsigned FLAG_V = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_FINISH
  } mul_state_t;

  // Bus output selects above the register file
  function automatic int unsigned sel_result(input int unsigned nregs);
    return nregs;
  endfunction

  function automatic int unsigned sel_result_hi(input int unsigned nregs);
    return nregs + 1;
  endfunction

  function automatic int unsigned sel_flags(input int unsigned nregs);
    return nregs + 2;
  endfunction

endpackage

// File: rtl/param_alu_mul.sv
// Sequential unsigned shift-add multiplier: one multiplier bit per cycle,
// then a one-cycle FINISH state in which the owner latches prod.
module param_alu_mul
  import param_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   mcand_in,
  input  logic [WIDTH-1:0]   mplier_in,
  output logic               busy,
  output logic               done,
  output logic               idle,
  output logic               fin,
  output logic [2*WIDTH-1:0] prod
);

  localparam int CW = $clog2(WIDTH + 1);

  mul_state_t         state;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;

  // busy drops on leaving MUL; done pulses on the FINISH edge, so done
  // appears WIDTH+1 edges after the start edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            mcand  <= {{WIDTH{1'b0}}, mcand_in};
            mplier <= mplier_in;
            acc    <= '0;
            cnt    <= CW'(WIDTH);
            busy   <= 1'b1;
            state  <= ST_MUL;
          end
        end
        ST_MUL: begin
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            busy  <= 1'b0;
            state <= ST_FINISH;
          end
        end
        ST_FINISH: begin
          done  <= 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign idle = (state == ST_IDLE);
  assign fin  = (state == ST_FINISH);
  assign prod = acc;

endmodule

// File: rtl/param_alu_core.sv
// Parametrised ALU core: operand register file, combinational ALU,
// result/result_hi/flags registers, bus output mux and shift-add multiplier.
module param_alu_core
  import param_alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NREGS = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [WIDTH-1:0]             bus_in,
  output logic [WIDTH-1:0]             bus_out,
  output logic                         bus_oe,
  input  logic                         load_en,
  input  logic [$clog2(NREGS)-1:0]     load_sel,
  input  logic                         out_en,
  input  logic [$clog2(NREGS+3)-1:0]   out_sel,
  input  logic                         calc,
  input  logic [2:0]                   op,
  input  logic [$clog2(NREGS)-1:0]     arg_l,
  input  logic [$clog2(NREGS)-1:0]     arg_r,
  input  logic                         use_cin,
  output logic                         busy,
  output logic                         done,
  output logic [3:0]                   flags
);

  logic [WIDTH-1:0]   regs [NREGS];
  logic [WIDTH-1:0]   result_q;
  logic [WIDTH-1:0]   result_hi_q;
  logic [3:0]         flags_q;

  alu_op_t            op_e;
  logic [WIDTH-1:0]   a_val;
  logic [WIDTH-1:0]   b_val;
  logic [WIDTH-1:0]   b_eff;
  logic               cin;
  logic [WIDTH:0]     sum_ext;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_c;
  logic               alu_v;
  logic [3:0]         alu_flags;
  logic [3:0]         mul_flags;

  logic               mul_idle;
  logic               mul_fin;
  logic [2*WIDTH-1:0] mul_prod;
  logic               alu_fire;
  logic               mul_start;

  assign op_e      = alu_op_t'(op);
  assign alu_fire  = calc && mul_idle && (op_e != OP_MUL);
  assign mul_start = calc && mul_idle && (op_e == OP_MUL);
  assign flags     = flags_q;

  param_alu_mul #(.WIDTH(WIDTH)) u_mul (
    .clk       (clk),
    .rst       (rst),
    .start     (mul_start),
    .mcand_in  (a_val),
    .mplier_in (b_val),
    .busy      (busy),
    .done      (done),
    .idle      (mul_idle),
    .fin       (mul_fin),
    .prod      (mul_prod)
  );

  // Register file load from the bus
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (load_en && (32'(load_sel) < NREGS)) begin
      regs[load_sel] <= bus_in;
    end
  end

  // Single-cycle ALU; SUB shares the adder via a + ~b + cin
  always_comb begin
    a_val = '0;
    b_val = '0;
    if (32'(arg_l) < NREGS) a_val = regs[arg_l];
    if (32'(arg_r) < NREGS) b_val = regs[arg_r];
    b_eff   = (op_e == OP_SUB) ? ~b_val : b_val;
    cin     = use_cin ? flags_q[FLAG_C] : (op_e == OP_SUB);
    sum_ext = {1'b0, a_val} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (op_e)
      OP_ADD, OP_SUB: begin
        alu_res = sum_ext[WIDTH-1:0];
        alu_c   = sum_ext[WIDTH];
        alu_v   = (a_val[WIDTH-1] == b_eff[WIDTH-1]) &&
                  (sum_ext[WIDTH-1] != a_val[WIDTH-1]);
      end
      OP_AND: alu_res = a_val & b_val;
      OP_OR:  alu_res = a_val | b_val;
      OP_XOR: alu_res = a_val ^ b_val;
      OP_SHL: begin
        alu_res = {a_val[WIDTH-2:0], 1'b0};
        alu_c   = a_val[WIDTH-1];
      end
      OP_SHR: begin
        alu_res = {1'b0, a_val[WIDTH-1:1]};
        alu_c   = a_val[0];
      end
      default: alu_res = '0;
    endcase
    alu_flags         = '0;
    alu_flags[FLAG_C] = alu_c;
    alu_flags[FLAG_Z] = (alu_res == '0);
    alu_flags[FLAG_N] = alu_res[WIDTH-1];
    alu_flags[FLAG_V] = alu_v;
    mul_flags         = '0;
    mul_flags[FLAG_C] = (mul_prod[2*WIDTH-1:WIDTH] != '0);
    mul_flags[FLAG_Z] = (mul_prod[WIDTH-1:0] == '0);
    mul_flags[FLAG_N] = mul_prod[WIDTH-1];
  end

  // Result and flag registers, written by ALU ops or multiplier completion
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q    <= '0;
      result_hi_q <= '0;
      flags_q     <= '0;
    end else if (alu_fire) begin
      result_q <= alu_res;
      flags_q  <= alu_flags;
    end else if (mul_fin) begin
      result_q    <= mul_prod[WIDTH-1:0];
      result_hi_q <= mul_prod[2*WIDTH-1:WIDTH];
      flags_q     <= mul_flags;
    end
  end

  // Bus output mux; unused select codes drive zero
  always_comb begin
    bus_oe  = out_en;
    bus_out = '0;
    if (32'(out_sel) < NREGS) begin
      bus_out = regs[out_sel[$clog2(NREGS)-1:0]];
    end else if (32'(out_sel) == sel_result(NREGS)) begin
      bus_out = result_q;
    end else if (32'(out_sel) == sel_result_hi(NREGS)) begin
      bus_out = result_hi_q;
    end else if (32'(out_sel) == sel_flags(NREGS)) begin
      bus_out[3:0] = flags_q;
    end
  end

endmodule

// File: tb/tb_param_alu_core.sv
// Directed bench for param_alu_core (WIDTH=8, NREGS=4): table of single-cycle
// ALU vectors plus hand-written multiply, abort and same-edge sequences.
module tb_param_alu_core;

  localparam int WIDTH = 8;
  localparam int NREGS = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] bus_in;
  logic [7:0] bus_out;
  logic       bus_oe;
  logic       load_en;
  logic [1:0] load_sel;
  logic       out_en;
  logic [2:0] out_sel;
  logic       calc;
  logic [2:0] op;
  logic [1:0] arg_l;
  logic [1:0] arg_r;
  logic       use_cin;
  logic       busy;
  logic       done;
  logic [3:0] flags;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  param_alu_core #(.WIDTH(WIDTH), .NREGS(NREGS)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus_in   (bus_in),
    .bus_out  (bus_out),
    .bus_oe   (bus_oe),
    .load_en  (load_en),
    .load_sel (load_sel),
    .out_en   (out_en),
    .out_sel  (out_sel),
    .calc     (calc),
    .op       (op),
    .arg_l    (arg_l),
    .arg_r    (arg_r),
    .use_cin  (use_cin),
    .busy     (busy),
    .done     (done),
    .flags    (flags)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
    logic       use_cin;
    logic [7:0] res;
    logic [3:0] fl;   // {V,N,Z,C}
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic read_chk(input string name, input logic [2:0] sel, input logic [7:0] exp);
    out_en  = 1'b1;
    out_sel = sel;
    #1;
    chk(name, {24'b0, bus_out}, {24'b0, exp});
    chk({name, "_oe"}, {31'b0, bus_oe}, 32'd1);
    out_en = 1'b0;
  endtask

  task automatic load_reg(input logic [1:0] idx, input logic [7:0] val);
    @(negedge clk);
    load_en  = 1'b1;
    load_sel = idx;
    bus_in   = val;
    @(negedge clk);
    load_en  = 1'b0;
  endtask

  task automatic do_calc(input logic [2:0] o, input logic [1:0] l, input logic [1:0] r,
                         input logic ci);
    @(negedge clk);
    calc    = 1'b1;
    op      = o;
    arg_l   = l;
    arg_r   = r;
    use_cin = ci;
    @(negedge clk);
    calc    = 1'b0;
    use_cin = 1'b0;
  endtask

  task automatic wait_done(input string name);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk(name, {31'b0, seen}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int busy_cnt;
    int done_cnt;
    int done_at;

    vecs[0]  = '{8'h7F, 8'h01, 3'd0, 1'b0, 8'h80, 4'b1100};
    vecs[1]  = '{8'h05, 8'h05, 3'd1, 1'b0, 8'h00, 4'b0011};
    vecs[2]  = '{8'h00, 8'h01, 3'd1, 1'b0, 8'hFF, 4'b0100};
    vecs[3]  = '{8'h05, 8'h05, 3'd1, 1'b0, 8'h00, 4'b0011};
    vecs[4]  = '{8'hFF, 8'h00, 3'd0, 1'b1, 8'h00, 4'b0011};
    vecs[5]  = '{8'h01, 8'h00, 3'd6, 1'b0, 8'h00, 4'b0011};
    vecs[6]  = '{8'hF0, 8'h3C, 3'd2, 1'b0, 8'h30, 4'b0000};
    vecs[7]  = '{8'hF0, 8'h0F, 3'd3, 1'b0, 8'hFF, 4'b0100};
    vecs[8]  = '{8'hAA, 8'hAA, 3'd4, 1'b0, 8'h00, 4'b0010};
    vecs[9]  = '{8'h81, 8'h00, 3'd5, 1'b0, 8'h02, 4'b0001};
    vecs[10] = '{8'h80, 8'h80, 3'd0, 1'b0, 8'h00, 4'b1011};
    vecs[11] = '{8'h10, 8'h01, 3'd1, 1'b1, 8'h0F, 4'b0001};
    vecs[12] = '{8'h80, 8'h01, 3'd1, 1'b1, 8'h7F, 4'b1001};
    vecs[13] = '{8'h01, 8'h01, 3'd0, 1'b1, 8'h03, 4'b0000};
    vecs[14] = '{8'h05, 8'h05, 3'd1, 1'b1, 8'hFF, 4'b0100};
    vecs[15] = '{8'h80, 8'h00, 3'd6, 1'b0, 8'h40, 4'b0000};

    bus_in = '0; load_en = 0; load_sel = '0; out_en = 0; out_sel = '0;
    calc = 0; op = '0; arg_l = '0; arg_r = '0; use_cin = 0;
    rst = 1'b0;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_flags", {28'b0, flags}, 32'd0);
    chk("rst_oe_idle", {31'b0, bus_oe}, 32'd0);
    read_chk("rst_result", 3'd4, 8'h00);
    read_chk("rst_r0", 3'd0, 8'h00);
    rst = 1'b0;

    // Table of single-cycle ops on R0/R1
    for (int i = 0; i < 16; i++) begin
      load_reg(2'd0, vecs[i].a);
      load_reg(2'd1, vecs[i].b);
      do_calc(vecs[i].op, 2'd0, 2'd1, vecs[i].use_cin);
      read_chk($sformatf("vec%0d_result", i), 3'd4, vecs[i].res);
      chk($sformatf("vec%0d_flags", i), {28'b0, flags}, {28'b0, vecs[i].fl});
    end
    read_chk("hi_untouched", 3'd5, 8'h00);

    // MUL 0x10*0x20: busy for 8 cycles, done on 9th edge after calc
    load_reg(2'd2, 8'h10);
    load_reg(2'd3, 8'h20);
    do_calc(3'd7, 2'd2, 2'd3, 1'b0);
    busy_cnt = 0; done_cnt = 0; done_at = 0;
    for (int k = 1; k <= 14; k++) begin
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_at == 0) done_at = k;
      end
      if (k == 2) read_chk("mul_old_result", 3'd4, 8'h40);
      @(negedge clk);
    end
    chk("mul_busy_cycles", busy_cnt, 8);
    chk("mul_done_edge", done_at, 10);
    chk("mul_done_pulses", done_cnt, 1);
    read_chk("mul_result_lo", 3'd4, 8'h00);
    read_chk("mul_result_hi", 3'd5, 8'h02);
    read_chk("mul_flags_bus", 3'd6, 8'h03);
    read_chk("sel_out_of_range", 3'd7, 8'h00);
    chk("mul_flags", {28'b0, flags}, 32'h3);

    // Ignored calc and operand load while multiplying 0x03*0x05
    load_reg(2'd0, 8'h03);
    load_reg(2'd1, 8'h05);
    do_calc(3'd7, 2'd0, 2'd1, 1'b0);
    do_calc(3'd0, 2'd2, 2'd3, 1'b0);
    chk("busy_calc_flags", {28'b0, flags}, 32'h3);
    read_chk("busy_calc_result", 3'd4, 8'h00);
    load_reg(2'd0, 8'hEE);
    wait_done("mul2_done_seen");
    @(negedge clk);
    read_chk("mul2_result_lo", 3'd4, 8'h0F);
    read_chk("mul2_result_hi", 3'd5, 8'h00);
    chk("mul2_flags", {28'b0, flags}, 32'h0);
    read_chk("mul2_r0_loaded", 3'd0, 8'hEE);

    // Reset mid-multiply aborts with no partial result
    do_calc(3'd7, 2'd2, 2'd3, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_flags", {28'b0, flags}, 32'd0);
    read_chk("abort_result", 3'd4, 8'h00);
    read_chk("abort_hi", 3'd5, 8'h00);
    read_chk("abort_r2", 3'd2, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    done_cnt = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    chk("abort_no_done", done_cnt, 0);

    // Same-edge load and calc: calc sees the pre-load value
    load_reg(2'd0, 8'h01);
    load_reg(2'd1, 8'h01);
    @(negedge clk);
    load_en = 1'b1; load_sel = 2'd0; bus_in = 8'hAA;
    calc = 1'b1; op = 3'd0; arg_l = 2'd0; arg_r = 2'd1; use_cin = 1'b0;
    @(negedge clk);
    load_en = 1'b0; calc = 1'b0;
    read_chk("same_edge_result", 3'd4, 8'h02);
    read_chk("same_edge_r0", 3'd0, 8'hAA);
    chk("same_edge_flags", {28'b0, flags}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
